convolutor_job_ctrl: RTL

//  Job sequencer for the convolution coprocessor. Accepts a host job command and configures sizeY.

---
 rtl/convolutor_ctrl_pkg.sv | 26 ++
 rtl/convolutor_watchdog.sv | 29 ++
 rtl/convolutor_job_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/convolutor_ctrl_pkg.sv
// Shared types and helpers for the convolution job sequencer.
package convolutor_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_RD_OUT,
        ST_FINISH
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_SIZE0   = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_COUNT   = 2'b11
    } err_e;

    // Number of Z words a convolution of a kernel of x_size with size Y samples produces.
    function automatic int unsigned exp_count(input int unsigned x_size, input int unsigned size);
        return x_size + size - 1;
    endfunction

endpackage

// File: rtl/convolutor_watchdog.sv
// Cycle watchdog for a running convolution; flags when the job has run out of time.
module convolutor_watchdog #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_PRE = CW'(TIMEOUT_CYC - 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear)
            cnt <= '0;
        else if (enable && cnt != CNT_MAX)
            cnt <= cnt + CW'(1);
    end

    // Fires on the cycle the count steps onto TIMEOUT_CYC-1, so the abort lands
    // exactly TIMEOUT_CYC cycles after the start pulse.
    assign expired = enable && (cnt == CNT_PRE);

endmodule

// File: rtl/convolutor_job_ctrl.sv
// Job sequencer: accepts a host job, runs the convolutor under a watchdog and
// write-count check, then streams the Z RAM out over a valid/ready port.
module convolutor_job_ctrl
    import convolutor_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 8,
    parameter int X_SIZE      = 5,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_size,
    input  logic                    cmd_readback,
    output logic                    conv_start,
    output logic [ADDR_WIDTH-1:0]   conv_size,
    input  logic                    conv_busy,
    input  logic                    conv_done,
    input  logic                    conv_writeZ,
    output logic [ADDR_WIDTH:0]     z_rd_addr,
    input  logic [2*DATA_WIDTH-1:0] z_rd_data,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2*DATA_WIDTH-1:0] res_data,
    output logic                    res_last,
    output logic                    job_done,
    output logic [1:0]              err_code
);

    localparam int CW = ADDR_WIDTH + 1;

    state_e                  state, state_nxt;
    err_e                    err_q, err_nxt;
    logic [ADDR_WIDTH-1:0]   size_q;
    logic                    readback_q;
    logic [CW-1:0]           wcnt, rd_ptr, expected;
    logic [2*DATA_WIDTH-1:0] res_q;
    logic                    wd_clear, wd_en, wd_expired;
    logic                    busy_unused;

    assign busy_unused = conv_busy;

    assign expected  = CW'(exp_count(X_SIZE, size_q));
    assign conv_size = size_q;
    assign z_rd_addr = rd_ptr;
    assign res_data  = res_q;
    assign err_code  = err_q;
    assign res_last  = (state == ST_RD_OUT) && (rd_ptr == expected - CW'(1));

    convolutor_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            err_q <= ERR_OK;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        err_nxt    = err_q;
        cmd_ready  = 1'b0;
        conv_start = 1'b0;
        res_valid  = 1'b0;
        job_done   = 1'b0;
        wd_clear   = 1'b0;
        wd_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_size == '0) begin
                        err_nxt   = ERR_SIZE0;
                        state_nxt = ST_FINISH;
                    end else begin
                        err_nxt   = ERR_OK;
                        state_nxt = ST_START;
                    end
                end
            end
            ST_START: begin
                conv_start = 1'b1;
                wd_clear   = 1'b1;
                state_nxt  = ST_RUN;
            end
            ST_RUN: begin
                wd_en = 1'b1;
                // done takes priority over a watchdog expiring in the same cycle
                if (conv_done) begin
                    if (wcnt != expected) begin
                        err_nxt   = ERR_COUNT;
                        state_nxt = ST_FINISH;
                    end else begin
                        state_nxt = readback_q ? ST_RD_ADDR : ST_FINISH;
                    end
                end else if (wd_expired) begin
                    err_nxt   = ERR_TIMEOUT;
                    state_nxt = ST_FINISH;
                end
            end
            ST_RD_ADDR: state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: state_nxt = ST_RD_OUT;
            ST_RD_OUT: begin
                res_valid = 1'b1;
                if (res_ready)
                    state_nxt = res_last ? ST_FINISH : ST_RD_ADDR;
            end
            ST_FINISH: begin
                job_done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            size_q     <= '0;
            readback_q <= 1'b0;
            wcnt       <= '0;
            rd_ptr     <= '0;
            res_q      <= '0;
        end else begin
            if (state == ST_IDLE && cmd_valid) begin
                size_q     <= cmd_size;
                readback_q <= cmd_readback;
                wcnt       <= '0;
            end
            if (state == ST_RUN && conv_writeZ && wcnt != {CW{1'b1}})
                wcnt <= wcnt + CW'(1);
            if (state == ST_RUN && conv_done)
                rd_ptr <= '0;
            else if (state == ST_RD_OUT && res_ready && !res_last)
                rd_ptr <= rd_ptr + CW'(1);
            // RAM answers one cycle after the address, i.e. during RD_WAIT
            if (state == ST_RD_WAIT)
                res_q <= z_rd_data;
        end
    end

endmodule
